mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/lsu_align.sv | 70 +++++++
 rtl/mem_wb_stage.sv | 106 ++++++++++
 tb/tb_mem_wb_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 encodings for the memory/write-back stage: ResultSrc selects,
// load/store funct3 codes and the memory-access FSM states.
package riscv_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // Stores share the low three codes with the signed loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replication, load extension
// and (when MEM_MISALIGN_CHECK_EN is defined) misalignment detection.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  store_be,
  output logic [31:0] store_wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = store_data;
    case (funct3)
      F3_B: begin
        store_be    = 4'b0001 << addr_lo;
        store_wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        store_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  // Unlisted funct3 codes fall through to a plain word access.
  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
      F3_H:    load_data = {{16{load_half[15]}}, load_half};
      F3_BU:   load_data = {24'h0, load_byte};
      F3_HU:   load_data = {16'h0, load_half};
      default: load_data = load_word;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = addr_lo[0];
      default:     misaligned = (addr_lo != 2'b00);
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage data-memory handshake plus MEM/WB pipeline register. Optional
// misaligned-access trapping is enabled with MEM_MISALIGN_CHECK_EN.
module mem_wb_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ResultSrcM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] InstrM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic [1:0]  ResultSrcW,
  output logic        RegWriteW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] InstrW,
  output logic        MisalignW
);

  mem_state_t  state, state_next;
  logic        is_load, access, misaligned, mis_fault, complete;
  logic [3:0]  store_be;
  logic [31:0] store_wdata, load_data;

  assign is_load   = (ResultSrcM == RES_LOAD);
  assign access    = MemWriteM | is_load;
  assign mis_fault = access & misaligned;

  lsu_align u_lsu_align (
    .funct3      (InstrM[14:12]),
    .addr_lo     (ALUResultM[1:0]),
    .store_data  (WriteDataM),
    .load_word   (dmem_rdata),
    .store_be    (store_be),
    .store_wdata (store_wdata),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  // Request fields come straight from EX/MEM, which StallM keeps frozen in WAIT.
  assign dmem_req   = !reset && ((state == S_IDLE && access && !mis_fault) || state == S_WAIT);
  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_wdata = store_wdata;
  assign dmem_be    = MemWriteM ? store_be : 4'b1111;
  assign StallM     = dmem_req & ~dmem_ready;
  assign complete   = (dmem_req & dmem_ready) | (state == S_IDLE && (!access || mis_fault));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (access && !mis_fault && !dmem_ready) state_next = S_WAIT;
      S_WAIT:  if (dmem_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ResultSrcW <= 2'b00;
      RegWriteW  <= 1'b0;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'h0;
      InstrW     <= 32'h0;
      MisalignW  <= 1'b0;
    end else if (complete) begin
      ResultSrcW <= ResultSrcM;
      RegWriteW  <= RegWriteM & ~mis_fault;
      ALUResultW <= ALUResultM;
      ReadDataW  <= is_load ? load_data : 32'h0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      InstrW     <= InstrM;
      MisalignW  <= mis_fault;
    end else if (StallM) begin
      // Bubble: only the architecturally visible fields are cleared.
      RegWriteW  <= 1'b0;
      RdW        <= 5'd0;
      MisalignW  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; expectations are hand-computed.
module tb_mem_wb_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ResultSrcM;
  logic        RegWriteM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, InstrM, PCPlus4M;
  logic [4:0]  RdM;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM;
  logic [1:0]  ResultSrcW;
  logic        RegWriteW, MisalignW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, InstrW;
  logic [4:0]  RdW;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .InstrM(InstrM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .StallM(StallM),
    .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .InstrW(InstrW),
    .MisalignW(MisalignW)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Loads in the instruction-field pattern the stage looks at (funct3, rd).
  task automatic set_op(input logic [1:0] rs, input logic rw, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc4);
    ResultSrcM = rs;
    RegWriteM  = rw;
    MemWriteM  = mw;
    ALUResultM = alu;
    WriteDataM = wd;
    InstrM     = {17'h0, f3, rd, 7'h03};
    RdM        = rd;
    PCPlus4M   = pc4;
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, "_rsw"}, {30'h0, ResultSrcW}, 32'h0);
    check({tag, "_rw"},  {31'h0, RegWriteW}, 32'h0);
    check({tag, "_alu"}, ALUResultW, 32'h0);
    check({tag, "_rd"},  ReadDataW, 32'h0);
    check({tag, "_rdw"}, {27'h0, RdW}, 32'h0);
    check({tag, "_pc"},  PCPlus4W, 32'h0);
    check({tag, "_ins"}, InstrW, 32'h0);
    check({tag, "_mis"}, {31'h0, MisalignW}, 32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0;
    // A load is presented during reset: no request may escape.
    set_op(RES_LOAD, 1'b1, 1'b0, 32'h200, 32'h0, F3_W, 5'd3, 32'h10);
    #1;
    check("rst_req", {31'h0, dmem_req}, 32'h0);
    check("rst_stall", {31'h0, StallM}, 32'h0);
    repeat (2) @(posedge clk);
    #1 check_w_zero("rst");

    // sw 0x100, ready in the same cycle
    @(negedge clk);
    reset = 1'b0;
    set_op(RES_ALU, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, F3_W, 5'd0, 32'h44);
    #1;
    check("sw_req", {31'h0, dmem_req}, 32'h1);
    check("sw_we", {31'h0, dmem_we}, 32'h1);
    check("sw_addr", dmem_addr, 32'h100);
    check("sw_be", {28'h0, dmem_be}, 32'hF);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    check("sw_stall", {31'h0, StallM}, 32'h0);
    @(posedge clk); #1;
    check("sw_rw", {31'h0, RegWriteW}, 32'h0);
    check("sw_pc", PCPlus4W, 32'h44);

    // sb 0x103
    @(negedge clk);
    set_op(RES_ALU, 1'b0, 1'b1, 32'h103, 32'h000000A5, F3_B, 5'd0, 32'h48);
    #1;
    check("sb_be", {28'h0, dmem_be}, 32'h8);
    check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    check("sb_addr", dmem_addr, 32'h100);

    // sh 0x102
    @(negedge clk);
    set_op(RES_ALU, 1'b0, 1'b1, 32'h102, 32'h00001234, F3_H, 5'd0, 32'h4C);
    #1;
    check("sh_be", {28'h0, dmem_be}, 32'hC);
    check("sh_wdata", dmem_wdata, 32'h12341234);

    // ALU pass-through; ready high but no request
    @(negedge clk);
    set_op(RES_ALU, 1'b1, 1'b0, 32'h55, 32'h0, F3_W, 5'd9, 32'h50);
    #1 check("alu_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    check("alu_rw", {31'h0, RegWriteW}, 32'h1);
    check("alu_rdw", {27'h0, RdW}, 32'd9);
    check("alu_res", ALUResultW, 32'h55);

    // lb 0x102 with three wait cycles
    @(negedge clk);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    set_op(RES_LOAD, 1'b1, 1'b0, 32'h102, 32'h0, F3_B, 5'd5, 32'h54);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lb_stall%0d", i), {31'h0, StallM}, 32'h1);
      check($sformatf("lb_req%0d", i), {31'h0, dmem_req}, 32'h1);
      check($sformatf("lb_addr%0d", i), dmem_addr, 32'h100);
      @(posedge clk); #1;
      check($sformatf("lb_bub_rw%0d", i), {31'h0, RegWriteW}, 32'h0);
      check($sformatf("lb_bub_rd%0d", i), {27'h0, RdW}, 32'h0);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0080FF00;
    #1;
    check("lb_stall_end", {31'h0, StallM}, 32'h0);
    check("lb_we", {31'h0, dmem_we}, 32'h0);
    check("lb_be", {28'h0, dmem_be}, 32'hF);
    @(posedge clk); #1;
    check("lb_data", ReadDataW, 32'hFFFFFF80);
    check("lb_rdw", {27'h0, RdW}, 32'd5);
    check("lb_rw", {31'h0, RegWriteW}, 32'h1);

    // Directed load table, all zero-wait
    begin
      logic [2:0]  f3s  [4] = '{F3_HU, F3_H, F3_BU, F3_W};
      logic [31:0] adrs [4] = '{32'h102, 32'h100, 32'h101, 32'h104};
      logic [31:0] rds  [4] = '{32'hBEEF1234, 32'h00008001, 32'h0000F000, 32'hCAFEF00D};
      logic [31:0] exps [4] = '{32'h0000BEEF, 32'hFFFF8001, 32'h000000F0, 32'hCAFEF00D};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        dmem_rdata = rds[i];
        set_op(RES_LOAD, 1'b1, 1'b0, adrs[i], 32'h0, f3s[i], 5'(10 + i), 32'h60);
        #1 check($sformatf("ld%0d_stall", i), {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        check($sformatf("ld%0d_data", i), ReadDataW, exps[i]);
        check($sformatf("ld%0d_rdw", i), {27'h0, RdW}, 32'(10 + i));
      end
    end

    // Reset during WAIT of an lw
    @(negedge clk);
    dmem_ready = 1'b0;
    set_op(RES_LOAD, 1'b1, 1'b0, 32'h200, 32'h0, F3_W, 5'd6, 32'h70);
    @(posedge clk); #1;
    check("rw_in_wait", {31'h0, StallM}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_req", {31'h0, dmem_req}, 32'h0);
    check_w_zero("rw");
    set_op(RES_ALU, 1'b1, 1'b0, 32'h77, 32'h0, F3_W, 5'd7, 32'h74);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rw_after_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    check("rw_next_rw", {31'h0, RegWriteW}, 32'h1);
    check("rw_next_rdw", {27'h0, RdW}, 32'd7);
    check("rw_next_alu", ALUResultW, 32'h77);

    // lw at 0x102: trapped with the check enabled, aligned down otherwise
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11223344;
    set_op(RES_LOAD, 1'b1, 1'b0, 32'h102, 32'h0, F3_W, 5'd8, 32'h80);
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_req", {31'h0, dmem_req}, 32'h0);
    check("mis_stall", {31'h0, StallM}, 32'h0);
    @(posedge clk); #1;
    check("mis_flag", {31'h0, MisalignW}, 32'h1);
    check("mis_rw", {31'h0, RegWriteW}, 32'h0);
    check("mis_pc", PCPlus4W, 32'h80);
    @(negedge clk);
    set_op(RES_ALU, 1'b0, 1'b0, 32'h0, 32'h0, F3_W, 5'd0, 32'h84);
    @(posedge clk); #1;
    check("mis_once", {31'h0, MisalignW}, 32'h0);
`else
    check("lwu_req", {31'h0, dmem_req}, 32'h1);
    check("lwu_addr", dmem_addr, 32'h100);
    @(posedge clk); #1;
    check("lwu_data", ReadDataW, 32'h11223344);
    check("lwu_rw", {31'h0, RegWriteW}, 32'h1);
    check("lwu_mis", {31'h0, MisalignW}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
